demux_dispatch_ctrl: RTL and testbench
======================================

// Module: demux_dispatch_ctrl
// PURPOSE
//  Sequencing controller for the 1-to-N output demultiplexer.
//  - Accepts one beat at a time from a valid/ready source and registers it.
//  - Steers the beat to exactly one of N_OUT sinks, each with its own valid/ready handshake.
//  - Target is either the source-supplied select (addressed mode) or an internal round-robin pointer.
//  - Sits between the upstream producer and the combinational demux fabric; provides cur_sel for that fabric.
// PARAMETERS
//  N_OUT   8   number of output channels, 2..2**SEL_W
//  SEL_W   3   select width
//  DW      8   data width
//  CNT_W   16  width of delivered-beat counter
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-high
//  en         in   1        1 = accept new beats
//  mode       in   1        0 = addressed (use in_sel), 1 = round-robin
//  in_valid   in   1        source beat valid
//  in_ready   out  1        controller can accept a beat
//  in_data    in   DW       source payload
//  in_sel     in   SEL_W    destination channel (addressed mode only)
//  out_valid  out  N_OUT    one-hot; bit k = beat pending for sink k
//  out_ready  in   N_OUT    per-sink ready
//  out_data   out  DW       registered payload, shared by all sinks
//  cur_sel    out  SEL_W    index of current or last target (drives demux select)
//  sel_err    out  1        one-cycle pulse: addressed beat with in_sel >= N_OUT dropped
//  tx_cnt     out  CNT_W    count of delivered beats, wraps at 2**CNT_W
// BEHAVIOUR
//  Reset values
//  - state=IDLE; out_valid=0; out_data=0; cur_sel=0; rr_ptr=0; sel_err=0; tx_cnt=0.
//  - in_ready is combinational: (state==IDLE) & en. It is 0 while rst is asserted.
//  FSM: IDLE, HOLD
//  - IDLE
//    - Accept when in_valid & in_ready.
//    - tgt = mode ? rr_ptr : in_sel.
//    - tgt < N_OUT: capture out_data<=in_data, cur_sel<=tgt, out_valid<=(1<<tgt), go HOLD.
//    - tgt >= N_OUT: addressed mode only. Drop the beat, pulse sel_err next cycle, stay IDLE, rr_ptr unchanged.
//  - HOLD
//    - in_ready=0. out_valid and out_data stay stable until out_ready[cur_sel]=1.
//    - On that edge: out_valid<=0, tx_cnt++, go IDLE.
//    - If mode=1 at capture, also rr_ptr <= (rr_ptr==N_OUT-1) ? 0 : rr_ptr+1.
//  Latency and throughput
//  - Source handshake to out_valid: 1 cycle.
//  - Maximum throughput: 1 beat per 2 cycles.
//  Ready rules
//  - out_ready on non-target bits is ignored.
//  - out_valid never depends combinationally on out_ready.
//  Mode and enable changes
//  - mode is sampled only at capture. A change during HOLD affects the next beat only.
//  - en=0 blocks new accepts only. A pending HOLD beat still completes.
//  Other rules
//  - rr_ptr advances only on delivered round-robin beats. Addressed beats never move it.
//  - cur_sel holds its last value in IDLE.
//  - Reset mid-HOLD: beat discarded, all state returns to reset values immediately.
// STRUCTURE
//  - Package demux_pkg: state enum {IDLE, HOLD}; MODE_ADDR=1'b0, MODE_RR=1'b1.
//  - Sub-module demux_rr_ptr: wrap-at-N_OUT pointer with an advance input. Async active-high reset.
//  - Top-level contents: FSM, capture register, one-hot decode, tx_cnt.
// TESTING
//  1 Addressed: mode=0, in_sel=5, in_data=8'hA5, out_ready=8'h20
//    -> out_valid=8'h20 one cycle after accept, out_data=A5, tx_cnt=1.
//  2 Round-robin: mode=1, 10 beats, out_ready=8'hFF
//    -> targets 0..7,0,1; tx_cnt=10; rr_ptr=2.
//  3 Backpressure: beat to sink 3, out_ready[3]=0 for 4 cycles, other ready bits=1
//    -> out_valid/out_data stable, in_ready=0 throughout, deliver on cycle 5.
//  4 Bad select: N_OUT=6, mode=0, in_sel=7
//    -> sel_err pulses 1 cycle, no out_valid, tx_cnt unchanged.
//  5 Reset mid-HOLD: assert rst during HOLD
//    -> out_valid=0 and tx_cnt=0 without a clock edge; in_ready=1 after release with en=1.
//  6 Enable gating: en=0 with in_valid=1
//    -> no accept; a beat already in HOLD still delivers.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the demux dispatch controller.
package demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

endpackage : demux_pkg

// File: rtl/demux_rr_ptr.sv
// Round-robin target pointer: counts 0..N_OUT-1 and wraps, one step per advance.
module demux_rr_ptr #(
    parameter int N_OUT = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    output logic [SEL_W-1:0] ptr_o
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);

    logic [SEL_W-1:0] ptr_q;

    // Pointer register; moves only when a round-robin beat is delivered.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (adv_i) begin
            ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + SEL_W'(1);
        end
    end

    assign ptr_o = ptr_q;

endmodule : demux_rr_ptr

// File: rtl/demux_dispatch_ctrl.sv
// Sequencing controller for a 1-to-N demux: registers one source beat and holds
// it on exactly one sink handshake (addressed or round-robin) until that sink takes it.
module demux_dispatch_ctrl
    import demux_pkg::*;
#(
    parameter int N_OUT = 8,
    parameter int SEL_W = 3,
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic [SEL_W-1:0] in_sel,
    output logic [N_OUT-1:0] out_valid,
    input  logic [N_OUT-1:0] out_ready,
    output logic [DW-1:0]    out_data,
    output logic [SEL_W-1:0] cur_sel,
    output logic             sel_err,
    output logic [CNT_W-1:0] tx_cnt
);

    localparam logic [N_OUT-1:0] ONE_HOT0 = N_OUT'(1);

    state_t           state_q, state_d;
    logic [N_OUT-1:0] out_valid_q;
    logic [DW-1:0]    out_data_q;
    logic [SEL_W-1:0] cur_sel_q;
    logic             sel_err_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic             rr_mode_q;   // mode captured with the held beat

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] tgt;
    logic             tgt_ok;
    logic             accept;
    logic             deliver;
    logic             rr_adv;

    // Target channel and its legality; rr_ptr is always in range, so only in_sel can be bad.
    assign tgt    = (mode == MODE_RR) ? rr_ptr : in_sel;
    assign tgt_ok = (int'(tgt) < N_OUT);
    assign accept = in_valid & in_ready;

    // Only the target bit of out_valid is set, so masking ignores non-target readies.
    assign deliver = (state_q == HOLD) & (|(out_ready & out_valid_q));
    assign rr_adv  = deliver & (rr_mode_q == MODE_RR);

    demux_rr_ptr #(
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_rr_ptr (
        .clk   (clk),
        .rst   (rst),
        .adv_i (rr_adv),
        .ptr_o (rr_ptr)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: IDLE captures a legal beat, HOLD waits for the target sink.
    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && tgt_ok) state_d = HOLD;
            HOLD:    if (deliver)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: source ready only when idle, enabled and out of reset.
    always_comb begin
        in_ready = (state_q == IDLE) & en & ~rst;
    end

    // Capture register, one-hot decode, error pulse and delivered-beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            cur_sel_q   <= '0;
            sel_err_q   <= 1'b0;
            tx_cnt_q    <= '0;
            rr_mode_q   <= MODE_ADDR;
        end else begin
            sel_err_q <= accept & ~tgt_ok;
            if (accept && tgt_ok) begin
                out_valid_q <= ONE_HOT0 << tgt;
                out_data_q  <= in_data;
                cur_sel_q   <= tgt;
                rr_mode_q   <= mode;
            end else if (deliver) begin
                out_valid_q <= '0;
                tx_cnt_q    <= tx_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cur_sel   = cur_sel_q;
    assign sel_err   = sel_err_q;
    assign tx_cnt    = tx_cnt_q;

endmodule : demux_dispatch_ctrl

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: directed beats with a delivery scoreboard on the
// 8-channel instance, plus a 6-channel instance for out-of-range selects.
module tb_demux_dispatch_ctrl;

    typedef struct packed {
        logic [7:0] onehot;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [2:0]  in_sel = '0;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready = '0;
    logic [7:0]  out_data;
    logic [2:0]  cur_sel;
    logic        sel_err;
    logic [15:0] tx_cnt;

    // 6-channel instance signals
    logic        s6_en = 1'b1;
    logic        s6_mode = 1'b0;
    logic        s6_in_valid = 1'b0;
    logic        s6_in_ready;
    logic [7:0]  s6_in_data = '0;
    logic [2:0]  s6_in_sel = '0;
    logic [5:0]  s6_out_valid;
    logic [5:0]  s6_out_ready = '1;
    logic [7:0]  s6_out_data;
    logic [2:0]  s6_cur_sel;
    logic        s6_sel_err;
    logic [15:0] s6_tx_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    demux_dispatch_ctrl #(.N_OUT(8), .SEL_W(3), .DW(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cur_sel(cur_sel), .sel_err(sel_err), .tx_cnt(tx_cnt)
    );

    demux_dispatch_ctrl #(.N_OUT(6), .SEL_W(3), .DW(8), .CNT_W(16)) dut6 (
        .clk(clk), .rst(rst), .en(s6_en), .mode(s6_mode),
        .in_valid(s6_in_valid), .in_ready(s6_in_ready), .in_data(s6_in_data), .in_sel(s6_in_sel),
        .out_valid(s6_out_valid), .out_ready(s6_out_ready), .out_data(s6_out_data),
        .cur_sel(s6_cur_sel), .sel_err(s6_sel_err), .tx_cnt(s6_tx_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: on every delivery handshake pop the oldest expected beat and compare.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ((out_valid & out_ready) != 8'h00)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_delivery", {24'h0, out_valid}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_out_valid", {24'h0, out_valid}, {24'h0, e.onehot});
                    check("sb_out_data", {24'h0, out_data}, {24'h0, e.data});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drive one beat on the 8-channel instance; returns 1 time unit after the accept edge.
    task automatic send(input logic m, input logic [2:0] sel, input logic [7:0] d,
                        input bit push, input logic [7:0] exp_oh);
        int n;
        @(posedge clk); #1;
        mode = m; in_sel = sel; in_data = d; in_valid = 1'b1;
        if (push) sb_q.push_back('{onehot: exp_oh, data: d});
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Drive one beat on the 6-channel instance (it is idle and enabled whenever this is used).
    task automatic send6(input logic m, input logic [2:0] sel, input logic [7:0] d);
        @(posedge clk); #1;
        s6_mode = m; s6_in_sel = sel; s6_in_data = d; s6_in_valid = 1'b1;
        check("s6_in_ready", {31'h0, s6_in_ready}, 32'd1);
        @(posedge clk); #1;
        s6_in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_out_valid", {24'h0, out_valid}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_tx_cnt", {16'h0, tx_cnt}, 32'h0);
        check("rst_cur_sel", {29'h0, cur_sel}, 32'h0);
        check("rst_out_data", {24'h0, out_data}, 32'h0);
        check("rst_sel_err", {31'h0, sel_err}, 32'h0);
        apply_reset();

        // 1: addressed beat to sink 5
        out_ready = 8'h20;
        send(1'b0, 3'd5, 8'hA5, 1'b1, 8'h20);
        check("t1_out_valid", {24'h0, out_valid}, 32'h20);
        check("t1_out_data", {24'h0, out_data}, 32'hA5);
        check("t1_in_ready_hold", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        check("t1_out_valid_done", {24'h0, out_valid}, 32'h0);
        check("t1_tx_cnt", {16'h0, tx_cnt}, 32'd1);
        check("t1_cur_sel_kept", {29'h0, cur_sel}, 32'd5);
        check("t1_in_ready_idle", {31'h0, in_ready}, 32'h1);

        // 2: ten round-robin beats, targets 0..7,0,1
        apply_reset();
        out_ready = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 3'd0, 8'h10 + 8'(i), 1'b1, 8'b1 << (i % 8));
        end
        @(posedge clk); #1;
        check("t2_tx_cnt", {16'h0, tx_cnt}, 32'd10);
        check("t2_cur_sel", {29'h0, cur_sel}, 32'd1);

        // 3: backpressure on sink 3 for four edges, other readies high
        out_ready = 8'hF7;
        send(1'b0, 3'd3, 8'h3C, 1'b1, 8'h08);
        for (int k = 0; k < 4; k++) begin
            check("t3_hold_valid", {24'h0, out_valid}, 32'h08);
            check("t3_hold_data", {24'h0, out_data}, 32'h3C);
            check("t3_hold_in_ready", {31'h0, in_ready}, 32'h0);
            @(posedge clk); #1;
        end
        check("t3_still_held", {24'h0, out_valid}, 32'h08);
        out_ready = 8'hFF;
        @(posedge clk); #1;
        check("t3_released", {24'h0, out_valid}, 32'h0);
        check("t3_tx_cnt", {16'h0, tx_cnt}, 32'd11);

        // rr pointer left at 2 by test 2; the addressed beat did not move it
        send(1'b1, 3'd0, 8'h5A, 1'b1, 8'h04);
        check("rr_resume_sel", {29'h0, cur_sel}, 32'd2);
        @(posedge clk); #1;
        check("rr_resume_tx", {16'h0, tx_cnt}, 32'd12);

        // 6: enable gating, including a beat already held when en drops
        en = 1'b0;
        @(posedge clk); #1;
        mode = 1'b0; in_sel = 3'd1; in_data = 8'h77; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t6_no_accept_ready", {31'h0, in_ready}, 32'h0);
            check("t6_no_accept_valid", {24'h0, out_valid}, 32'h0);
        end
        in_valid = 1'b0;
        en = 1'b1;
        out_ready = 8'h00;
        send(1'b0, 3'd6, 8'h66, 1'b1, 8'h40);
        en = 1'b0;
        in_valid = 1'b1; in_data = 8'h99; in_sel = 3'd0;
        @(posedge clk); #1;
        check("t6_held_valid", {24'h0, out_valid}, 32'h40);
        out_ready = 8'hFF;
        @(posedge clk); #1;
        check("t6_delivered_tx", {16'h0, tx_cnt}, 32'd13);
        @(posedge clk); #1;
        check("t6_no_new_accept", {24'h0, out_valid}, 32'h0);
        in_valid = 1'b0;
        en = 1'b1;

        // 5: reset asserted mid-HOLD, checked before any clock edge
        out_ready = 8'h00;
        send(1'b0, 3'd4, 8'h44, 1'b0, 8'h10);
        check("t5_in_hold", {24'h0, out_valid}, 32'h10);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_out_valid", {24'h0, out_valid}, 32'h0);
        check("t5_rst_tx_cnt", {16'h0, tx_cnt}, 32'h0);
        check("t5_rst_cur_sel", {29'h0, cur_sel}, 32'h0);
        check("t5_rst_in_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t5_in_ready_after", {31'h0, in_ready}, 32'h1);
        check("t5_out_valid_after", {24'h0, out_valid}, 32'h0);

        // 4: 6-channel instance, selects 7 and 6 are dropped, 5 is the last legal one
        send6(1'b0, 3'd7, 8'hEE);
        check("t4_sel_err_pulse", {31'h0, s6_sel_err}, 32'h1);
        check("t4_no_valid", {26'h0, s6_out_valid}, 32'h0);
        check("t4_still_ready", {31'h0, s6_in_ready}, 32'h1);
        @(posedge clk); #1;
        check("t4_sel_err_one_cycle", {31'h0, s6_sel_err}, 32'h0);
        check("t4_tx_unchanged", {16'h0, s6_tx_cnt}, 32'h0);
        send6(1'b0, 3'd6, 8'hE6);
        check("t4_sel6_err", {31'h0, s6_sel_err}, 32'h1);
        send6(1'b0, 3'd5, 8'hE5);
        check("t4_sel5_valid", {26'h0, s6_out_valid}, 32'h20);
        check("t4_sel5_no_err", {31'h0, s6_sel_err}, 32'h0);
        check("t4_sel5_data", {24'h0, s6_out_data}, 32'hE5);
        @(posedge clk); #1;
        check("t4_sel5_tx", {16'h0, s6_tx_cnt}, 32'd1);

        @(posedge clk); #1;
        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_demux_dispatch_ctrl
